// File: rtl/vending_pkg.sv
// Shared constants for the vending machine sequencer: state codes,
// coin denominations and default product prices.
package vending_pkg;

  // State encodings kept as plain 3-bit constants so the debug port maps
  // directly onto existing logic-analyser decodes.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_VEND    = 3'd3;
  localparam logic [2:0] S_CHANGE  = 3'd4;
  localparam logic [2:0] S_CLEAR   = 3'd5;

  // Coin denominations available in the hopper, largest first.
  localparam logic [3:0] COIN_10 = 4'd10;
  localparam logic [3:0] COIN_5  = 4'd5;
  localparam logic [3:0] COIN_2  = 4'd2;
  localparam logic [3:0] COIN_1  = 4'd1;

  // Default product prices in currency units.
  localparam int PRICE_0_DEF = 7;
  localparam int PRICE_1_DEF = 12;
  localparam int PRICE_2_DEF = 15;
  localparam int PRICE_3_DEF = 20;

endpackage

// File: rtl/change_dispenser.sv
// Pays out an amount one coin at a time, always choosing the largest coin
// that still fits, over a valid/ack handshake with the coin hopper.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int CASH_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CASH_W-1:0] amount_in,
  input  logic              coin_ack,
  output logic              coin_valid,
  output logic [3:0]        coin_val,
  output logic              done
);

  logic [CASH_W-1:0] amount;
  logic              active;
  logic [3:0]        coin_sel;

  // Greedy selection: largest denomination not exceeding what is still owed.
  // NOTE: every signal assigned in a combinational block gets a default
  // first, so no path leaves it holding a value and no latch is inferred.
  always_comb begin
    coin_sel = COIN_1;
    if (amount >= CASH_W'(COIN_10))     coin_sel = COIN_10;
    else if (amount >= CASH_W'(COIN_5)) coin_sel = COIN_5;
    else if (amount >= CASH_W'(COIN_2)) coin_sel = COIN_2;
  end

  // The coin offered is derived from the held amount, so it cannot move
  // until the hopper acknowledges it.
  assign coin_valid = active && (amount != '0);
  assign coin_val   = coin_valid ? coin_sel : 4'd0;
  assign done       = active && (amount == '0);

  // Amount register: load on start, deduct one coin per acknowledged transfer.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      amount <= '0;
      active <= 1'b0;
    end else if (start) begin
      amount <= amount_in;
      active <= 1'b1;
    end else if (done) begin
      active <= 1'b0;
    end else if (coin_valid && coin_ack) begin
      amount <= amount - CASH_W'(coin_sel);
    end
  end

endmodule

// File: rtl/vending_seq_ctrl.sv
// Top-level vending sequencer: product selection, cash collection with
// cancel/timeout/wrap refund, settle window for late notes, dispense
// handshake and change payout through change_dispenser.
module vending_seq_ctrl
  import vending_pkg::*;
#(
  parameter int CASH_W  = 7,
  parameter int PRICE_0 = PRICE_0_DEF,
  parameter int PRICE_1 = PRICE_1_DEF,
  parameter int PRICE_2 = PRICE_2_DEF,
  parameter int PRICE_3 = PRICE_3_DEF,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_valid,
  input  logic [1:0]        sel_id,
  input  logic              cancel,
  input  logic [CASH_W-1:0] cash,
  output logic              acc_en,
  output logic              acc_clr,
  output logic              disp_valid,
  input  logic              disp_ack,
  output logic [1:0]        disp_id,
  output logic              coin_valid,
  input  logic              coin_ack,
  output logic [3:0]        coin_val,
  output logic              busy,
  output logic [2:0]        state
);

  // Idle counter only needs to reach TIMEOUT-1.
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0]        state_next;
  logic [1:0]        prod;
  logic [CASH_W-1:0] price;
  logic [CASH_W-1:0] sel_price;
  logic [CASH_W-1:0] pay_amt;
  logic [CASH_W-1:0] cash_prev;
  logic [TO_W-1:0]   idle_cnt;
  logic              settle_cnt;
  logic              cash_changed;
  logic              cash_wrapped;
  logic              timeout;
  logic              chg_start;
  logic [CASH_W-1:0] chg_amount;
  logic              chg_done;

  assign cash_changed = (cash != cash_prev);
  assign cash_wrapped = (cash < cash_prev);
  assign timeout      = (TIMEOUT != 0) && !cash_changed &&
                        (idle_cnt == TO_W'(TIMEOUT - 1));

  // Price lookup for the product being selected.
  always_comb begin
    case (sel_id)
      2'd0:    sel_price = CASH_W'(PRICE_0);
      2'd1:    sel_price = CASH_W'(PRICE_1);
      2'd2:    sel_price = CASH_W'(PRICE_2);
      default: sel_price = CASH_W'(PRICE_3);
    endcase
  end

  // Next-state logic; also launches the payout with the amount owed.
  always_comb begin
    state_next = state;
    chg_start  = 1'b0;
    chg_amount = pay_amt;
    case (state)
      S_IDLE:
        if (sel_valid) state_next = S_COLLECT;
      S_COLLECT:
        // Cancel, timeout and accumulator wrap all refund and beat a met price.
        if (cancel || timeout || cash_wrapped) begin
          if (cash == '0) begin
            state_next = S_CLEAR;
          end else begin
            state_next = S_CHANGE;
            chg_start  = 1'b1;
            chg_amount = cash;
          end
        end else if (cash >= price) begin
          state_next = S_SETTLE;
        end
      S_SETTLE:
        if (settle_cnt) state_next = S_VEND;
      S_VEND:
        if (disp_ack) begin
          if (pay_amt == '0) begin
            state_next = S_CLEAR;
          end else begin
            state_next = S_CHANGE;
            chg_start  = 1'b1;
          end
        end
      S_CHANGE:
        if (chg_done) state_next = S_CLEAR;
      S_CLEAR:
        state_next = S_IDLE;
      default:
        state_next = S_IDLE;
    endcase
  end

  // State, latched transaction data, settle and timeout counters.
  // NOTE: every register, including the latched transaction data, is cleared
  // by reset so no stale product or amount survives into the next sale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      acc_clr    <= 1'b0;
      prod       <= 2'd0;
      price      <= '0;
      pay_amt    <= '0;
      cash_prev  <= '0;
      idle_cnt   <= '0;
      settle_cnt <= 1'b0;
    end else begin
      state      <= state_next;
      acc_clr    <= (state_next == S_CLEAR);
      cash_prev  <= cash;
      settle_cnt <= (state == S_SETTLE) && !settle_cnt;
      if (state == S_IDLE && sel_valid) begin
        prod  <= sel_id;
        price <= sel_price;
      end
      // Second settle cycle: late notes have landed, take the excess.
      if (state == S_SETTLE && settle_cnt)
        pay_amt <= (cash >= price) ? (cash - price) : '0;
      if (state == S_COLLECT && !cash_changed && TIMEOUT != 0)
        idle_cnt <= idle_cnt + TO_W'(1);
      else
        idle_cnt <= '0;
    end
  end

  assign acc_en     = (state == S_COLLECT);
  assign disp_valid = (state == S_VEND);
  assign disp_id    = disp_valid ? prod : 2'd0;
  assign busy       = (state != S_IDLE);

  change_dispenser #(
    .CASH_W (CASH_W)
  ) u_change (
    .clk        (clk),
    .rst        (rst),
    .start      (chg_start),
    .amount_in  (chg_amount),
    .coin_ack   (coin_ack),
    .coin_valid (coin_valid),
    .coin_val   (coin_val),
    .done       (chg_done)
  );

endmodule
